dma_wr_burst_ctrl: RTL and testbench
====================================

DMA_WR_BURST_CTRL -- requirements
Module: dma_wr_burst_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data beat width (one word per beat).
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter LEN_W, default 16, transfer length width in words.
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum beats per burst (1..16).
REQ-005 SHALL have parameter FIFO_AW, default 5, FIFO address width (depth 2**FIFO_AW = 32).
REQ-006 SHALL have ports, with clk and rst first: clk in 1 sole clock, rising edge; rst in 1 asynchronous, active-high reset.
REQ-007 SHALL have ports: start in 1 one-cycle command pulse; dst_addr in ADDR_W word-aligned start address; xfer_len in LEN_W words to move.
REQ-008 SHALL have ports: busy out 1 transfer active; done out 1 one-cycle completion pulse; err out 1 sticky error flag.
REQ-009 SHALL have ports: fifo_pull out 1 pop; fifo_data in DWIDTH fall-through head word; fifo_empty in 1; fifo_depth_left in FIFO_AW+1 free slots (32 = empty).
REQ-010 SHALL have ports: awvalid out 1; awaddr out ADDR_W; awlen out 8 (beats-1); awready in 1.
REQ-011 SHALL have ports: wvalid out 1; wdata out DWIDTH; wlast out 1; wready in 1; bvalid in 1; bresp in 2; bready out 1.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_DATA, ADDR, DATA, RESP, with a single outstanding burst.
REQ-013 IDLE: start with xfer_len!=0 latches dst_addr and xfer_len, sets busy, clears err, and goes to WAIT_DATA; start with xfer_len==0 pulses done next cycle and stays IDLE.
REQ-014 SHALL ignore start while busy (no relatch, no effect).
REQ-015 Burst length blen SHALL be min(remaining, MAX_BURST, words to next 4 KB boundary), where words_to_4k = (4096 - addr[11:0]) >> 2; bursts never cross 4 KB.
REQ-016 WAIT_DATA: occupancy = 2**FIFO_AW - fifo_depth_left; SHALL advance to ADDR only when occupancy >= blen, so W beats never stall on FIFO.
REQ-017 ADDR: awvalid=1, awaddr=current addr, awlen=blen-1 held stable until awready; on handshake go to DATA the following cycle.
REQ-018 DATA: wvalid=1, wdata=fifo_data (combinational), fifo_pull = wvalid & wready; wlast=1 on beat blen; after last handshake go to RESP.
REQ-019 fifo_pull SHALL never assert while fifo_empty=1 or outside DATA.
REQ-020 RESP: bready=1; on bvalid with bresp==0, addr += blen*4 and remaining -= blen; if remaining==0 pulse done and go IDLE, else go WAIT_DATA.
REQ-021 On bvalid with bresp!=0, SHALL set err, pulse done, clear busy, and go IDLE; unsent words stay in FIFO.
REQ-022 busy SHALL be 1 in every state except IDLE; done SHALL assert for exactly one cycle per accepted command.
REQ-023 Address arithmetic SHALL wrap modulo 2**ADDR_W; remaining SHALL never underflow.
REQ-024 awvalid and wvalid SHALL never be asserted in the same cycle.

Reset
REQ-025 On rst=1, asynchronously: FSM to IDLE; busy, done, err, fifo_pull, awvalid, wvalid, wlast, bready all 0; awaddr, awlen, and internal counters 0.
REQ-026 rst mid-burst SHALL abandon the transfer with no further fifo_pull; after deassertion the block accepts a new start.

Verification
REQ-027 addr=0x1000, len=8, FIFO holds 8, all readies 1 -> one AW awlen=7, 8 W beats with wlast on beat 8, 8 pulls, done one cycle after B.
REQ-028 addr=0x0FF8, len=20 -> bursts awlen=1 @0x0FF8, awlen=15 @0x1000, awlen=1 @0x1040; done once.
REQ-029 len=16, FIFO fills one word per 4 cycles -> awvalid held low until occupancy reaches 16; no pull while empty.
REQ-030 len=32, bresp=2 on first B -> err=1, done pulse, busy=0, 16 words remain in FIFO (depth_left=16).
REQ-031 rst asserted during DATA beat 5 -> all outputs 0 same cycle; new start then completes normally.
REQ-032 start pulse while busy with different len -> ignored; original transfer completes with its own length.

Source files
------------

// File: rtl/dma_wr_burst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_wr_burst_ctrl : FIFO-to-AXI write DMA, single outstanding burst.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dma_wr_burst_ctrl #(
  parameter int DWIDTH    = 32,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16,
  parameter int FIFO_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              fifo_pull,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic [FIFO_AW:0]  fifo_depth_left,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  input  logic              awready,
  output logic              wvalid,
  output logic [DWIDTH-1:0] wdata,
  output logic              wlast,
  input  logic              wready,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready
);

  localparam int BL_W = $clog2(MAX_BURST + 1);
  localparam int CW   = ((LEN_W > 13) ? LEN_W : 13) + 1;
  localparam int FW   = FIFO_AW + 1;
  localparam logic [FW-1:0] C_FIFO_DEPTH = FW'(1) << FIFO_AW;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_ADDR      = 3'd2,
    ST_DATA      = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [BL_W-1:0]   r_blen;
  logic [BL_W-1:0]   r_beats_left;

  logic [CW-1:0]     w_words_4k;
  logic [CW-1:0]     w_blen_c;
  logic [FW-1:0]     w_occ;

  // Next burst size: bounded by remaining words, MAX_BURST and the 4 KB page end.
  always_comb begin
    w_words_4k = (CW'(13'h1000) - CW'(r_addr[11:0])) >> 2;
    w_blen_c   = CW'(r_remaining);
    if (CW'(MAX_BURST) < w_blen_c) w_blen_c = CW'(MAX_BURST);
    if (w_words_4k < w_blen_c)     w_blen_c = w_words_4k;
    w_occ      = C_FIFO_DEPTH - fifo_depth_left;
  end

  assign fifo_pull = wvalid & wready & ~fifo_empty;
  assign wdata     = fifo_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_blen       <= '0;
      r_beats_left <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      awvalid      <= 1'b0;
      awaddr       <= '0;
      awlen        <= '0;
      wvalid       <= 1'b0;
      wlast        <= 1'b0;
      bready       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (xfer_len != '0) begin
              r_addr      <= dst_addr;
              r_remaining <= xfer_len;
              busy        <= 1'b1;
              err         <= 1'b0;
              r_state     <= ST_WAIT_DATA;
            end else begin
              done <= 1'b1;
            end
          end
        end
        // Holding the AW until the whole burst is buffered keeps W free of bubbles.
        ST_WAIT_DATA: begin
          if (CW'(w_occ) >= w_blen_c) begin
            r_blen  <= BL_W'(w_blen_c);
            awaddr  <= r_addr;
            awlen   <= 8'(w_blen_c - CW'(1));
            awvalid <= 1'b1;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (awready) begin
            awvalid      <= 1'b0;
            wvalid       <= 1'b1;
            wlast        <= (r_blen == BL_W'(1));
            r_beats_left <= r_blen;
            r_state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wready) begin
            if (wlast) begin
              wvalid  <= 1'b0;
              wlast   <= 1'b0;
              bready  <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_beats_left <= r_beats_left - BL_W'(1);
              wlast        <= (r_beats_left == BL_W'(2));
            end
          end
        end
        ST_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != 2'b00) begin
              err     <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_addr      <= r_addr + (ADDR_W'(r_blen) << 2);
              r_remaining <= r_remaining - LEN_W'(r_blen);
              if (r_remaining == LEN_W'(r_blen)) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_WAIT_DATA;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_wr_burst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dma_wr_burst_ctrl : bench with FIFO/AXI slave models and burst model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dma_wr_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dst_addr;
  logic [15:0] xfer_len;
  logic        busy, done, err, fifo_pull, fifo_empty;
  logic [31:0] fifo_data;
  logic [5:0]  fifo_depth_left;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [1:0]  bresp;

  always #5 clk = ~clk;

  dma_wr_burst_ctrl #(.DWIDTH(32), .ADDR_W(32), .LEN_W(16), .MAX_BURST(16), .FIFO_AW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr), .xfer_len(xfer_len),
    .busy(busy), .done(done), .err(err), .fifo_pull(fifo_pull), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_depth_left(fifo_depth_left), .awvalid(awvalid),
    .awaddr(awaddr), .awlen(awlen), .awready(awready), .wvalid(wvalid), .wdata(wdata),
    .wlast(wlast), .wready(wready), .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  // FIFO model: word value encodes its push index so order can be verified.
  logic [31:0] fifo_mem [32];
  int   wr_ptr = 0, rd_ptr = 0, push_target = 0, push_gap = 1, cyc = 0;
  logic flush = 1'b0;

  assign fifo_empty      = (wr_ptr == rd_ptr);
  assign fifo_depth_left = 6'(32 - (wr_ptr - rd_ptr));
  assign fifo_data       = fifo_mem[rd_ptr[4:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush)          rd_ptr <= wr_ptr;
    else if (fifo_pull) rd_ptr <= rd_ptr + 1;
    if (!flush && wr_ptr < push_target && (wr_ptr - rd_ptr) < 32 && (cyc % push_gap) == 0) begin
      fifo_mem[wr_ptr[4:0]] <= 32'hA500_0000 + 32'(wr_ptr);
      wr_ptr <= wr_ptr + 1;
    end
  end

  // AXI write slave: drives #1 after each rising edge.
  int   wlast_cnt = 0, b_hs_cnt = 0, err_b_abs = -1;
  logic rnd_ready = 1'b0;

  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
    forever begin
      @(posedge clk); #1;
      awready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = (b_hs_cnt < wlast_cnt);
      bresp   = (b_hs_cnt == err_b_abs) ? 2'd2 : 2'd0;
    end
  end

  // Monitor on the falling edge.
  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  aw_t  aw_log[$];
  aw_t  exp_q[$];
  int   exp_words;
  int   beats = 0, done_cnt = 0, beat_idx = 0;
  logic [7:0]  cur_len = 8'd0;
  int   viol_wlast = 0, viol_data = 0, viol_occ = 0, viol_pull_empty = 0;
  int   viol_aw_w = 0, viol_done2 = 0, viol_aw_stable = 0;
  logic prev_done = 1'b0, prev_aw_wait = 1'b0;
  logic [39:0] prev_aw = 40'd0;

  always @(negedge clk) begin
    if (rst) begin
      beat_idx     <= 0;
      prev_done    <= 1'b0;
      prev_aw_wait <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_log.push_back(aw_t'{awaddr, awlen});
        cur_len <= awlen;
      end
      if (prev_aw_wait && (!awvalid || {awaddr, awlen} != prev_aw)) viol_aw_stable <= viol_aw_stable + 1;
      prev_aw_wait <= awvalid && !awready;
      prev_aw      <= {awaddr, awlen};
      if (awvalid && (32 - int'(fifo_depth_left)) < int'(awlen) + 1) viol_occ <= viol_occ + 1;
      if (awvalid && wvalid) viol_aw_w <= viol_aw_w + 1;
      if (fifo_pull && fifo_empty) viol_pull_empty <= viol_pull_empty + 1;
      if (wvalid && wready) begin
        beats <= beats + 1;
        if (wdata !== 32'hA500_0000 + 32'(rd_ptr)) viol_data <= viol_data + 1;
        if (wlast !== (beat_idx == int'(cur_len))) viol_wlast <= viol_wlast + 1;
        beat_idx <= wlast ? 0 : beat_idx + 1;
        if (wlast) wlast_cnt <= wlast_cnt + 1;
      end
      if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (done && prev_done) viol_done2 <= viol_done2 + 1;
      prev_done <= done;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: split a transfer into bursts from the page/size rules alone.
  function automatic void build_model(input logic [31:0] addr, input int len, input int err_idx);
    logic [31:0] a = addr;
    int rem = len, b, w4k;
    exp_q.delete();
    exp_words = 0;
    while (rem > 0) begin
      w4k = (4096 - int'(a & 32'hFFF)) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (w4k < b) b = w4k;
      exp_q.push_back(aw_t'{a, 8'(b - 1)});
      exp_words += b;
      if (exp_q.size() - 1 == err_idx) break;
      a = a + 32'(4 * b);
      rem -= b;
    end
  endfunction

  int last_aw0;

  task automatic run_xfer(input logic [31:0] addr, input int len, input int gap,
                          input bit prefill, input int err_idx_in, input bit intrude);
    int aw0, beats0, done0, rd0, n, nexp, err_idx;
    err_idx = err_idx_in;
    @(posedge clk); #1; push_target = wr_ptr; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    build_model(addr, len, err_idx);
    if (err_idx >= exp_q.size()) err_idx = -1;
    aw0 = aw_log.size(); last_aw0 = aw0;
    beats0 = beats; done0 = done_cnt; rd0 = rd_ptr;
    err_b_abs   = (err_idx >= 0) ? b_hs_cnt + err_idx : -1;
    push_gap    = gap;
    push_target = wr_ptr + len;
    if (prefill) begin
      repeat (gap * 34 + 2) @(posedge clk);
      #1;
    end
    start = 1'b1; dst_addr = addr; xfer_len = 16'(len);
    @(posedge clk); #1; start = 1'b0;
    if (intrude) begin
      repeat (3) @(posedge clk);
      #1; start = 1'b1; dst_addr = addr + 32'h100; xfer_len = 16'(len / 2 + 1);
      @(posedge clk); #1; start = 1'b0;
    end
    n = 0;
    while (done_cnt == done0 && n < 4000) begin
      @(posedge clk); n++;
    end
    check("done_timeout", (n < 4000), 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - done0, 1);
    check("busy_end", busy, 0);
    check("err_end", err, (err_idx >= 0));
    nexp = exp_q.size();
    check("aw_count", aw_log.size() - aw0, nexp);
    for (int i = 0; i < nexp && aw0 + i < aw_log.size(); i++) begin
      check("aw_addr", aw_log[aw0 + i].addr, exp_q[i].addr);
      check("aw_len", aw_log[aw0 + i].len, exp_q[i].len);
    end
    check("w_beats", beats - beats0, exp_words);
    check("pulls", rd_ptr - rd0, exp_words);
  endtask

  typedef struct { logic [31:0] addr; int len; int nb; int first_len; int last_len; } vec_t;
  vec_t tbl[8];

  initial begin
    int n, beats0, rd0;
    logic [31:0] a;
    tbl[0] = '{32'h0000_1000,  8, 1,  7,  7};
    tbl[1] = '{32'h0000_0FF8, 20, 3,  1,  1};
    tbl[2] = '{32'h0000_0000, 16, 1, 15, 15};
    tbl[3] = '{32'h0000_2000, 17, 2, 15,  0};
    tbl[4] = '{32'h0000_0FFC,  1, 1,  0,  0};
    tbl[5] = '{32'h0000_0FFC,  3, 2,  0,  1};
    tbl[6] = '{32'hFFFF_FFF8,  4, 2,  1,  1};
    tbl[7] = '{32'h0000_3FC0, 40, 3, 15,  7};

    rst = 1'b1; start = 1'b0; dst_addr = '0; xfer_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {busy, done, err, fifo_pull, awvalid, wvalid, wlast, bready}, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_awlen", awlen, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_xfer(tbl[i].addr, tbl[i].len, 1, 1, -1, 0);
      check("tbl_nbursts", aw_log.size() - last_aw0, tbl[i].nb);
      check("tbl_first_len", aw_log[last_aw0].len, tbl[i].first_len);
      check("tbl_last_len", aw_log[aw_log.size() - 1].len, tbl[i].last_len);
    end

    // Zero-length command: done next cycle, never busy.
    @(posedge clk); #1; start = 1'b1; xfer_len = 16'd0; dst_addr = 32'h40;
    @(posedge clk); #1; start = 1'b0;
    check("zlen_done", done, 1);
    check("zlen_busy", busy, 0);
    @(posedge clk); #1;
    check("zlen_done_clr", done, 0);

    // Slow producer: AW must wait for the full burst to be buffered.
    run_xfer(32'h0000_5000, 16, 4, 0, -1, 0);

    // Error response on first B leaves the second half in the FIFO.
    run_xfer(32'h0000_6000, 32, 1, 1, 0, 0);
    check("err_depth_left", fifo_depth_left, 16);
    check("err_sticky", err, 1);

    // Start while busy is ignored.
    run_xfer(32'h0000_7000, 8, 1, 1, -1, 1);

    // Reset during beat 5.
    @(posedge clk); #1; push_target = wr_ptr; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; push_gap = 1; push_target = wr_ptr + 16;
    repeat (40) @(posedge clk);
    #1; beats0 = beats;
    start = 1'b1; dst_addr = 32'h0000_8000; xfer_len = 16'd16;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (beats - beats0 < 4 && n < 200) begin
      @(posedge clk); n++;
    end
    check("rst_mid_reach", (n < 200), 1);
    @(posedge clk); #2;
    check("rst_mid_wvalid", wvalid, 1);
    rst = 1'b1; #1;
    check("rst_mid_ctrl", {busy, done, err, fifo_pull, awvalid, wvalid, wlast, bready}, 0);
    check("rst_mid_aw", {awaddr, awlen}, 0);
    rd0 = rd_ptr;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_nopull", rd_ptr - rd0, 0);
    run_xfer(32'h0000_9000, 12, 1, 1, -1, 0);

    // Randomized transfers with random AXI back-pressure.
    rnd_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      a = $urandom & 32'hFFFF_F000;
      if ($urandom_range(0, 1) == 1) a = a | 32'(4096 - 4 * $urandom_range(1, 24));
      else                           a = a | ($urandom & 32'h0000_0FFC);
      run_xfer(a, $urandom_range(1, 48), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1, 0);
    end
    rnd_ready = 1'b0;

    check("viol_wlast", viol_wlast, 0);
    check("viol_wdata", viol_data, 0);
    check("viol_occupancy", viol_occ, 0);
    check("viol_pull_empty", viol_pull_empty, 0);
    check("viol_aw_and_w", viol_aw_w, 0);
    check("viol_done_width", viol_done2, 0);
    check("viol_aw_stable", viol_aw_stable, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
